// File: rtl/i2c_color_target.sv
// i2c_color_target: I2C target emulating a TCS3472-class colour sensor for colorlite
// Ports: clk, rst (async, active high); scl_in/sda_in bus levels, sda_oe pulls SDA low;
//   sample_valid strobes clear_in/red_in/green_in/blue_in into the data registers;
//   enable_reg/atime_reg/gain_reg mirror registers 0x00/0x01/0x0F; busy is high START..STOP.
// Build option: SHADOW_LATCH_EN makes a read of 0x14 freeze bytes 0x15-0x1B in a shadow bank.
module i2c_color_target #(
   parameter logic [6:0] TGT_ADDR = 7'h29,
   parameter logic [7:0] DEV_ID   = 8'h44
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic        sample_valid,
   input  logic [15:0] clear_in,
   input  logic [15:0] red_in,
   input  logic [15:0] green_in,
   input  logic [15:0] blue_in,
   output logic [7:0]  enable_reg,
   output logic [7:0]  atime_reg,
   output logic [1:0]  gain_reg,
   output logic        busy
);
   typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE} state_t;
   state_t      state;
   logic [2:0]  scl_q, sda_q;
   logic [3:0]  bit_cnt;
   logic [7:0]  shreg, txb, rd_byte;
   logic [4:0]  ptr;
   logic        rw, auto_inc, ack_ok, avalid;
   logic [15:0] clr_d, red_d, grn_d, blu_d;
   logic [7:0]  clr_h_v;
   logic [15:0] red_v, grn_v, blu_v;
   logic        scl_rise, scl_fall, is_start, is_stop, load_tx;
   // [0],[1] synchronise, [2] holds the previous synchronised level for edge detection
   assign scl_rise = scl_q[1] & ~scl_q[2];
   assign scl_fall = ~scl_q[1] & scl_q[2];
   assign is_start = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
   assign is_stop  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
   assign load_tx  = (state == ADDR_ACK && rw) || (state == RD_ACK && ack_ok);
`ifdef SHADOW_LATCH_EN
   logic [7:0]  sh_clr_h;
   logic [15:0] sh_red, sh_grn, sh_blu;
   assign clr_h_v = sh_clr_h;
   assign red_v   = sh_red;
   assign grn_v   = sh_grn;
   assign blu_v   = sh_blu;
`else
   assign clr_h_v = clr_d[15:8];
   assign red_v   = red_d;
   assign grn_v   = grn_d;
   assign blu_v   = blu_d;
`endif
   always_comb begin
      rd_byte = 8'h00;
      case (ptr)
         5'h00: rd_byte = enable_reg;
         5'h01: rd_byte = atime_reg;
         5'h0F: rd_byte = {6'b0, gain_reg};
         5'h12: rd_byte = DEV_ID;
         5'h13: rd_byte = {7'b0, avalid};
         5'h14: rd_byte = clr_d[7:0];
         5'h15: rd_byte = clr_h_v;
         5'h16: rd_byte = red_v[7:0];
         5'h17: rd_byte = red_v[15:8];
         5'h18: rd_byte = grn_v[7:0];
         5'h19: rd_byte = grn_v[15:8];
         5'h1A: rd_byte = blu_v[7:0];
         5'h1B: rd_byte = blu_v[15:8];
         default: rd_byte = 8'h00;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl_in};
         sda_q <= {sda_q[1:0], sda_in};
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= 4'd0;
         shreg      <= 8'h00;
         txb        <= 8'h00;
         ptr        <= 5'd0;
         rw         <= 1'b0;
         auto_inc   <= 1'b0;
         ack_ok     <= 1'b0;
         sda_oe     <= 1'b0;
         busy       <= 1'b0;
         enable_reg <= 8'h00;
         atime_reg  <= 8'hFF;
         gain_reg   <= 2'b00;
         avalid     <= 1'b0;
         clr_d      <= 16'h0;
         red_d      <= 16'h0;
         grn_d      <= 16'h0;
         blu_d      <= 16'h0;
`ifdef SHADOW_LATCH_EN
         sh_clr_h   <= 8'h0;
         sh_red     <= 16'h0;
         sh_grn     <= 16'h0;
         sh_blu     <= 16'h0;
`endif
      end else begin
         // judged against the pre-write enable value; a same-cycle AEN=0 write below wins on avalid
         if (sample_valid && enable_reg[1:0] == 2'b11) begin
            clr_d  <= clear_in;
            red_d  <= red_in;
            grn_d  <= green_in;
            blu_d  <= blue_in;
            avalid <= 1'b1;
         end
         if (is_stop) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else if (is_start) begin
            state   <= ADDR;
            bit_cnt <= 4'd0;
            busy    <= 1'b1;
         end else if (scl_rise) begin
            if (bit_cnt < 4'd8) begin
               shreg   <= {shreg[6:0], sda_q[1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == RD_ACK) ack_ok <= ~sda_q[1];
         end else if (scl_fall) begin
            case (state)
               ADDR: if (bit_cnt == 4'd8) begin
                  rw     <= shreg[0];
                  sda_oe <= (shreg[7:1] == TGT_ADDR);
                  state  <= (shreg[7:1] == TGT_ADDR) ? ADDR_ACK : IGNORE;
               end
               ADDR_ACK: begin
                  bit_cnt <= 4'd0;
                  sda_oe  <= 1'b0;
                  state   <= rw ? RD : CMD;
               end
               CMD: if (bit_cnt == 4'd8) begin
                  if (shreg[7]) begin
                     auto_inc <= (shreg[6:5] == 2'b01);
                     ptr      <= shreg[4:0];
                     sda_oe   <= 1'b1;
                     state    <= CMD_ACK;
                  end else state <= IGNORE;
               end
               CMD_ACK, WR_ACK: begin
                  bit_cnt <= 4'd0;
                  sda_oe  <= 1'b0;
                  state   <= WR;
               end
               WR: if (bit_cnt == 4'd8) begin
                  if (ptr == 5'h00) begin
                     enable_reg <= shreg;
                     if (!shreg[1]) avalid <= 1'b0;
                  end else if (ptr == 5'h01) atime_reg <= shreg;
                  else if (ptr == 5'h0F) gain_reg <= shreg[1:0];
                  ptr    <= ptr + {4'b0, auto_inc};
                  sda_oe <= 1'b1;
                  state  <= WR_ACK;
               end
               // pointer advances per byte sent, so the next byte is fetched from the new ptr
               RD: if (bit_cnt == 4'd8) begin
                  sda_oe <= 1'b0;
                  ptr    <= ptr + {4'b0, auto_inc};
                  state  <= RD_ACK;
               end else begin
                  txb    <= {txb[6:0], 1'b0};
                  sda_oe <= ~txb[6];
               end
               RD_ACK: begin
                  bit_cnt <= 4'd0;
                  state   <= ack_ok ? RD : IGNORE;
               end
               default: ;
            endcase
            if (load_tx) begin
               txb    <= rd_byte;
               sda_oe <= ~rd_byte[7];
`ifdef SHADOW_LATCH_EN
               if (ptr == 5'h14) begin
                  sh_clr_h <= clr_d[15:8];
                  sh_red   <= red_d;
                  sh_grn   <= grn_d;
                  sh_blu   <= blu_d;
               end
`endif
            end
         end
      end
endmodule

// File: tb/tb_i2c_color_target.sv
// tb_i2c_color_target: bit-banged I2C initiator with a bus-sniffing scoreboard for i2c_color_target
module tb_i2c_color_target;
   localparam int Q = 100;
`ifdef SHADOW_LATCH_EN
   localparam bit SH = 1'b1;
`else
   localparam bit SH = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b1;
   logic        scl_m = 1'b1, sda_m = 1'b1, sda_bus;
   logic        sample_valid = 1'b0;
   logic [15:0] clear_in = '0, red_in = '0, green_in = '0, blue_in = '0;
   logic        sda_oe, busy;
   logic [7:0]  enable_reg, atime_reg;
   logic [1:0]  gain_reg;
   logic [8:0]  exp_q[$];
   int          n_vec = 0, n_bad = 0;
   logic        mon_ps, mon_pd, mon_act;
   logic [8:0]  mon_fr, mon_exp;
   int          mon_nb, mon_idx;
   assign sda_bus = sda_m & ~sda_oe;
   always #5 clk = ~clk;
   i2c_color_target dut (
      .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
      .sample_valid(sample_valid), .clear_in(clear_in), .red_in(red_in),
      .green_in(green_in), .blue_in(blue_in), .enable_reg(enable_reg),
      .atime_reg(atime_reg), .gain_reg(gain_reg), .busy(busy)
   );
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic bitx(input logic b);
      sda_m = b; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
   endtask
   task automatic i2c_start;
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask
   task automatic i2c_stop;
      sda_m = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b1; #Q;
   endtask
   // frame = {byte on bus, ack bit on bus}; ack bit 0 means acknowledged
   task automatic wb(input logic [7:0] d, input logic ack);
      exp_q.push_back({d, ~ack});
      for (int i = 7; i >= 0; i--) bitx(d[i]);
      bitx(1'b1);
   endtask
   task automatic rb(input logic [7:0] e, input logic ack);
      exp_q.push_back({e, ~ack});
      for (int i = 0; i < 8; i++) bitx(1'b1);
      bitx(~ack);
   endtask
   task automatic wr1(input logic [7:0] cmd, input logic [7:0] d);
      i2c_start; wb(8'h52, 1); wb(cmd, 1); wb(d, 1); i2c_stop; #Q;
   endtask
   task automatic rd1(input logic [7:0] cmd, input logic [7:0] e);
      i2c_start; wb(8'h52, 1); wb(cmd, 1); i2c_start; wb(8'h53, 1); rb(e, 0); i2c_stop; #Q;
   endtask
   task automatic pulse(input logic [15:0] c, input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
      clear_in = c; red_in = r; green_in = g; blue_in = b;
      @(negedge clk); sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0;
   endtask
   initial begin
      mon_ps = 1'b1; mon_pd = 1'b1; mon_act = 1'b0; mon_nb = 0; mon_fr = '0; mon_idx = 0;
      forever begin
         @(scl_m or sda_bus);
         if (!mon_ps && scl_m) begin
            if (mon_act) begin
               mon_fr = {mon_fr[7:0], sda_bus};
               mon_nb++;
               if (mon_nb == 9) begin
                  mon_nb = 0;
                  mon_idx++;
                  n_vec++;
                  if (exp_q.size() == 0) begin
                     n_bad++;
                     $display("FAIL frame %0d: got %h want no frame", mon_idx, mon_fr);
                  end else begin
                     mon_exp = exp_q.pop_front();
                     if (mon_fr !== mon_exp) begin
                        n_bad++;
                        $display("FAIL frame %0d: got %h want %h", mon_idx, mon_fr, mon_exp);
                     end
                  end
               end
            end
         end else if (mon_ps && scl_m && mon_pd === 1'b1 && sda_bus === 1'b0) begin
            mon_act = 1'b1;
            mon_nb = 0;
         end else if (mon_ps && scl_m && mon_pd === 1'b0 && sda_bus === 1'b1) mon_act = 1'b0;
         mon_ps = scl_m;
         mon_pd = sda_bus;
      end
   end
   initial begin
      #950_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
   initial begin
      repeat (4) @(negedge clk);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_enable", enable_reg, 8'h00);
      chk("rst_atime", atime_reg, 8'hFF);
      chk("rst_gain", gain_reg, 2'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      i2c_start; wb(8'h52, 1);
      chk("busy_mid", busy, 1);
      wb(8'h80, 1); wb(8'h03, 1);
      chk("enable_after_ack", enable_reg, 8'h03);
      i2c_stop; #Q;
      chk("busy_after_stop", busy, 0);
      pulse(16'h1234, 16'hABCD, 16'h6789, 16'hEF01);
      i2c_start; wb(8'h52, 1); wb(8'hB4, 1); i2c_start; wb(8'h53, 1);
      rb(8'h34, 1); rb(8'h12, 1); rb(8'hCD, 1); rb(8'hAB, 0); i2c_stop; #Q;
      i2c_start; wb(8'h53, 1); rb(8'h89, 0); i2c_stop; #Q;
      i2c_start; wb(8'h54, 0); wb(8'h80, 0); wb(8'h00, 0); i2c_stop; #Q;
      chk("enable_wrong_addr", enable_reg, 8'h03);
      rd1(8'h92, 8'h44);
      i2c_start; wb(8'h52, 1); wb(8'h93, 1); i2c_start; wb(8'h53, 1);
      rb(8'h01, 1); rb(8'h01, 1); rb(8'h01, 0); i2c_stop; #Q;
      wr1(8'h8F, 8'hFE);
      chk("gain_write", gain_reg, 2'd2);
      wr1(8'h81, 8'hC0);
      chk("atime_write", atime_reg, 8'hC0);
      rd1(8'h8F, 8'h02);
      wr1(8'h92, 8'h77);
      rd1(8'h92, 8'h44);
      i2c_start; wb(8'h52, 1); wb(8'hBF, 1); i2c_start; wb(8'h53, 1);
      rb(8'h00, 1); rb(8'h03, 0); i2c_stop; #Q;
      i2c_start; wb(8'h52, 1); wb(8'h00, 0); wb(8'h00, 0); i2c_stop; #Q;
      chk("enable_bad_cmd", enable_reg, 8'h03);
      i2c_start; wb(8'h52, 1); wb(8'hB4, 1); i2c_start; wb(8'h53, 1);
      rb(8'h34, 1);
      pulse(16'h1234, 16'h5555, 16'h6789, 16'hEF01);
      rb(8'h12, 1); rb(SH ? 8'hCD : 8'h55, 1); rb(SH ? 8'hAB : 8'h55, 0); i2c_stop; #Q;
      wr1(8'h80, 8'h01);
      chk("enable_pon_only", enable_reg, 8'h01);
      pulse(16'h1234, 16'h1111, 16'h6789, 16'hEF01);
      rd1(8'h93, 8'h00);
      rd1(8'h96, SH ? 8'hCD : 8'h55);
      i2c_start; wb(8'h52, 1); wb(8'h80, 1); i2c_start; wb(8'h53, 1);
      chk("rd_drive_low", sda_oe, 1);
      rst = 1'b1; #1;
      chk("async_rst_sda_oe", sda_oe, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_enable", enable_reg, 8'h00);
      chk("async_rst_atime", atime_reg, 8'hFF);
      chk("async_rst_gain", gain_reg, 2'd0);
      @(negedge clk); @(negedge clk); rst = 1'b0;
      repeat (4) @(negedge clk);
      i2c_stop; #Q;
      wr1(8'h80, 8'h03);
      chk("enable_after_rst", enable_reg, 8'h03);
      i2c_start; wb(8'h52, 1); wb(8'hB3, 1); i2c_start; wb(8'h53, 1);
      rb(8'h00, 1); rb(8'h00, 0); i2c_stop; #Q;
      for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending frames want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
